// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM duty scheduler.
// Holds the FSM state enum, the duty width and the default duty parameters.
package pwm_pkg;

    localparam int DUTY_W            = 4;
    localparam int DEFAULT_DUTY_MAX  = 10;
    localparam int DEFAULT_DUTY_INIT = 5;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

    // Move a duty value one count toward a goal; no change when already there.
    function automatic logic [DUTY_W-1:0] step_toward(
        input logic [DUTY_W-1:0] cur,
        input logic [DUTY_W-1:0] goal
    );
        logic [DUTY_W-1:0] res;
        res = cur;
        if (goal > cur) begin
            res = cur + DUTY_W'(1);
        end else if (goal < cur) begin
            res = cur - DUTY_W'(1);
        end
        return res;
    endfunction

endpackage

// File: rtl/pwm_duty_scheduler_if.sv
// Host set-target handshake for the PWM duty scheduler.
// master = host side, slave = scheduler side.
interface pwm_duty_scheduler_if;
    import pwm_pkg::*;

    logic              host_valid;
    logic [DUTY_W-1:0] host_duty;
    logic              host_ready;

    modport master (
        output host_valid,
        output host_duty,
        input  host_ready
    );

    modport slave (
        input  host_valid,
        input  host_duty,
        output host_ready
    );

endinterface

// File: rtl/pwm_ramp_tick.sv
// Ramp prescaler: counts period_wrap pulses and issues a one-cycle step on
// every RAMP_DIV-th pulse. clr holds the count at zero and suppresses step.
// step is combinational so the duty update lands on the wrap cycle itself.
module pwm_ramp_tick #(
    parameter int RAMP_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic period_wrap,
    output logic step
);

    localparam logic [7:0] DIV_LAST = 8'(RAMP_DIV - 1);

    logic [7:0] cnt_reg;

    assign step = period_wrap && !clr && (cnt_reg == DIV_LAST);

    // Count wrap pulses, restarting after each step or on clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= 8'd0;
        end else if (clr) begin
            cnt_reg <= 8'd0;
        end else if (period_wrap) begin
            if (cnt_reg == DIV_LAST) begin
                cnt_reg <= 8'd0;
            end else begin
                cnt_reg <= cnt_reg + 8'd1;
            end
        end
    end

endmodule

// File: rtl/pwm_duty_scheduler.sv
// PWM duty scheduler: holds a target duty set by host or buttons and moves
// the applied duty toward it on PWM period boundaries.
// Build option: define PWM_SCHED_RAMP_EN to ramp one count per RAMP_DIV
// periods; without it the full target is applied at the next period wrap.
module pwm_duty_scheduler
    import pwm_pkg::*;
#(
    parameter int DUTY_MAX  = DEFAULT_DUTY_MAX,
    parameter int DUTY_INIT = DEFAULT_DUTY_INIT,
    parameter int RAMP_DIV  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     period_wrap,
    input  logic                     btn_inc,
    input  logic                     btn_dec,
    pwm_duty_scheduler_if.slave      host,
    output logic [DUTY_W-1:0]        duty_out,
    output logic [DUTY_W-1:0]        target_out,
    output logic                     busy,
    output logic                     clamp_err
);

    localparam logic [DUTY_W-1:0] DMAX  = DUTY_W'(DUTY_MAX);
    localparam logic [DUTY_W-1:0] DINIT = DUTY_W'(DUTY_INIT);

    state_t            state_reg, state_next;
    logic [DUTY_W-1:0] target_reg, target_next;
    logic [DUTY_W-1:0] duty_reg, duty_next;
    logic              host_ready_reg;
    logic              clamp_err_reg;
    logic              host_accept;

    assign host_accept = host.host_valid && host_ready_reg;

    // Target update: accepted host request wins, then a lone button press.
    always_comb begin
        target_next = target_reg;
        if (host_accept) begin
            target_next = (host.host_duty > DMAX) ? DMAX : host.host_duty;
        end else if (btn_inc && !btn_dec) begin
            if (target_reg < DMAX) begin
                target_next = target_reg + DUTY_W'(1);
            end
        end else if (btn_dec && !btn_inc) begin
            if (target_reg != '0) begin
                target_next = target_reg - DUTY_W'(1);
            end
        end
    end

`ifdef PWM_SCHED_RAMP_EN
    logic step;
    logic reverse;
    logic tick_clr;

    // A target that crosses to the other side of duty_out restarts the count.
    assign reverse  = (state_reg == RAMP) && (target_next != duty_reg) &&
                      ((target_next > duty_reg) != (target_reg > duty_reg));
    assign tick_clr = (state_reg == IDLE) || reverse;

    pwm_ramp_tick #(
        .RAMP_DIV    (RAMP_DIV)
    ) u_ramp_tick (
        .clk         (clk),
        .rst         (rst),
        .clr         (tick_clr),
        .period_wrap (period_wrap),
        .step        (step)
    );

    // One count toward the target per prescaler step.
    always_comb begin
        duty_next = duty_reg;
        if (step) begin
            duty_next = step_toward(duty_reg, target_next);
        end
    end
`else
    // Apply the whole target at the first period wrap after it changed.
    always_comb begin
        duty_next = duty_reg;
        if ((state_reg == RAMP) && period_wrap) begin
            duty_next = target_next;
        end
    end
`endif

    // RAMP whenever the applied duty will differ from the target.
    always_comb begin
        state_next = (target_next != duty_next) ? RAMP : IDLE;
    end

    // State, target, duty and handshake registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            target_reg     <= DINIT;
            duty_reg       <= DINIT;
            host_ready_reg <= 1'b0;
            clamp_err_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            target_reg     <= target_next;
            duty_reg       <= duty_next;
            host_ready_reg <= (state_next == IDLE);
            clamp_err_reg  <= host_accept && (host.host_duty > DMAX);
        end
    end

    assign host.host_ready = host_ready_reg;
    assign duty_out        = duty_reg;
    assign target_out      = target_reg;
    assign busy            = (state_reg == RAMP);
    assign clamp_err       = clamp_err_reg;

endmodule

// File: tb/tb_pwm_duty_scheduler.sv
// Directed bench for pwm_duty_scheduler with default parameters
// (DUTY_MAX=10, DUTY_INIT=5, RAMP_DIV=4). Expectations follow the build
// option PWM_SCHED_RAMP_EN so the same bench covers both builds.
module tb_pwm_duty_scheduler;

`ifdef PWM_SCHED_RAMP_EN
    localparam bit RAMP_EN = 1'b1;
`else
    localparam bit RAMP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       period_wrap;
    logic       btn_inc;
    logic       btn_dec;
    logic [3:0] duty_out;
    logic [3:0] target_out;
    logic       busy;
    logic       clamp_err;

    int checks   = 0;
    int failures = 0;

    pwm_duty_scheduler_if host_if ();

    pwm_duty_scheduler #(
        .DUTY_MAX    (10),
        .DUTY_INIT   (5),
        .RAMP_DIV    (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .period_wrap (period_wrap),
        .btn_inc     (btn_inc),
        .btn_dec     (btn_dec),
        .host        (host_if.slave),
        .duty_out    (duty_out),
        .target_out  (target_out),
        .busy        (busy),
        .clamp_err   (clamp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       inc;
        logic       dec;
        logic       hv;
        logic [3:0] hd;
        logic [3:0] exp_target;
        logic       exp_clamp;
        logic       exp_busy;
        logic       exp_ready;
    } vec_t;

    vec_t vecs[18];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic host_set(input logic [3:0] d);
        host_if.host_valid = 1'b1;
        host_if.host_duty  = d;
        tick();
        host_if.host_valid = 1'b0;
        host_if.host_duty  = 4'd0;
    endtask

    task automatic wrap_pulse();
        period_wrap = 1'b1;
        tick();
        period_wrap = 1'b0;
        tick();
    endtask

    task automatic pulse_dec();
        btn_dec = 1'b1;
        tick();
        btn_dec = 1'b0;
    endtask

    task automatic set_vec(input int i, input string n, input logic inc, input logic dec,
                           input logic hv, input logic [3:0] hd, input logic [3:0] t,
                           input logic c, input logic b, input logic r);
        vecs[i] = '{n, inc, dec, hv, hd, t, c, b, r};
    endtask

    initial begin
        int exp_duty;
        logic [3:0] exp_t;

        // name, inc, dec, host_valid, host_duty, target, clamp, busy, ready
        set_vec( 0, "host13_clamp",   0, 0, 1, 4'd13, 4'd10, 1, 1, 0);
        set_vec( 1, "clamp_one_cycle",0, 0, 0, 4'd0,  4'd10, 0, 1, 0);
        set_vec( 2, "host_ignored",   0, 0, 1, 4'd2,  4'd10, 0, 1, 0);
        set_vec( 3, "inc_sat_max",    1, 0, 0, 4'd0,  4'd10, 0, 1, 0);
        set_vec( 4, "incdec_at_max",  1, 1, 0, 4'd0,  4'd10, 0, 1, 0);
        set_vec( 5, "dec_to_9",       0, 1, 0, 4'd0,  4'd9,  0, 1, 0);
        set_vec( 6, "incdec_at_9",    1, 1, 0, 4'd0,  4'd9,  0, 1, 0);
        set_vec( 7, "dec_to_8",       0, 1, 0, 4'd0,  4'd8,  0, 1, 0);
        set_vec( 8, "dec_to_7",       0, 1, 0, 4'd0,  4'd7,  0, 1, 0);
        set_vec( 9, "dec_to_6",       0, 1, 0, 4'd0,  4'd6,  0, 1, 0);
        set_vec(10, "dec_to_5_idle",  0, 1, 0, 4'd0,  4'd5,  0, 0, 1);
        set_vec(11, "host3_drop_inc", 1, 0, 1, 4'd3,  4'd3,  0, 1, 0);
        set_vec(12, "dec_to_2",       0, 1, 0, 4'd0,  4'd2,  0, 1, 0);
        set_vec(13, "dec_to_1",       0, 1, 0, 4'd0,  4'd1,  0, 1, 0);
        set_vec(14, "dec_to_0",       0, 1, 0, 4'd0,  4'd0,  0, 1, 0);
        set_vec(15, "dec_sat_zero",   0, 1, 0, 4'd0,  4'd0,  0, 1, 0);
        set_vec(16, "incdec_at_0",    1, 1, 0, 4'd0,  4'd0,  0, 1, 0);
        set_vec(17, "inc_from_0",     1, 0, 0, 4'd0,  4'd1,  0, 1, 0);

        rst                = 1'b1;
        period_wrap        = 1'b0;
        btn_inc            = 1'b0;
        btn_dec            = 1'b0;
        host_if.host_valid = 1'b0;
        host_if.host_duty  = 4'd0;

        // Reset state while rst is held, then host_ready after release.
        tick();
        tick();
        check("rst_duty",   duty_out,   4'd5);
        check("rst_target", target_out, 4'd5);
        check("rst_busy",   {3'b0, busy},            4'd0);
        check("rst_clamp",  {3'b0, clamp_err},       4'd0);
        check("rst_ready",  {3'b0, host_if.host_ready}, 4'd0);
        rst = 1'b0;
        tick();
        check("ready_after_release", {3'b0, host_if.host_ready}, 4'd1);
        $display("reset: duty=%0d target=%0d ready=%0d", duty_out, target_out, host_if.host_ready);

        // Target update vectors; no period_wrap so duty_out stays at 5.
        for (int i = 0; i < 18; i++) begin
            btn_inc            = vecs[i].inc;
            btn_dec            = vecs[i].dec;
            host_if.host_valid = vecs[i].hv;
            host_if.host_duty  = vecs[i].hd;
            tick();
            btn_inc            = 1'b0;
            btn_dec            = 1'b0;
            host_if.host_valid = 1'b0;
            host_if.host_duty  = 4'd0;
            $display("vec %s: target=%0d clamp=%0d busy=%0d ready=%0d", vecs[i].name,
                     target_out, clamp_err, busy, host_if.host_ready);
            check({vecs[i].name, "_target"}, target_out, vecs[i].exp_target);
            check({vecs[i].name, "_clamp"}, {3'b0, clamp_err}, {3'b0, vecs[i].exp_clamp});
            check({vecs[i].name, "_busy"}, {3'b0, busy}, {3'b0, vecs[i].exp_busy});
            check({vecs[i].name, "_ready"}, {3'b0, host_if.host_ready}, {3'b0, vecs[i].exp_ready});
            check({vecs[i].name, "_duty"}, duty_out, 4'd5);
        end

        // Seven btn_inc pulses from 5 saturate at 10; inc+dec together holds.
        do_reset();
        for (int i = 1; i <= 7; i++) begin
            btn_inc = 1'b1;
            tick();
            btn_inc = 1'b0;
            exp_t = (5 + i > 10) ? 4'd10 : 4'(5 + i);
            $display("inc %0d: target=%0d", i, target_out);
            check("inc_run_target", target_out, exp_t);
        end
        btn_inc = 1'b1;
        btn_dec = 1'b1;
        tick();
        btn_inc = 1'b0;
        btn_dec = 1'b0;
        check("incdec_hold", target_out, 4'd10);

        // Host sets 8: ramp 6,7,8 every 4th wrap, or a jump to 8 without ramping.
        do_reset();
        host_set(4'd8);
        check("h8_target", target_out, 4'd8);
        check("h8_busy",   {3'b0, busy}, 4'd1);
        for (int n = 1; n <= 12; n++) begin
            wrap_pulse();
            exp_duty = RAMP_EN ? ((n / 4 >= 3) ? 8 : 5 + n / 4) : 8;
            $display("wrap %0d: duty=%0d busy=%0d ready=%0d", n, duty_out, busy, host_if.host_ready);
            check("h8_duty",  duty_out, 4'(exp_duty));
            check("h8_busy",  {3'b0, busy}, {3'b0, (exp_duty != 8)});
            check("h8_ready", {3'b0, host_if.host_ready}, {3'b0, (exp_duty == 8)});
        end

        // Mid-ramp retarget downward.
        do_reset();
        host_set(4'd9);
`ifdef PWM_SCHED_RAMP_EN
        for (int n = 0; n < 8; n++) wrap_pulse();
        check("mid_duty7", duty_out, 4'd7);
        wrap_pulse();
        wrap_pulse();
        pulse_dec();
        pulse_dec();
        pulse_dec();
        check("mid_target6", target_out, 4'd6);
        check("mid_busy",    {3'b0, busy}, 4'd1);
        for (int n = 0; n < 3; n++) wrap_pulse();
        check("mid_restart_hold", duty_out, 4'd7);
        wrap_pulse();
        check("mid_duty6", duty_out, 4'd6);
        check("mid_idle",  {3'b0, busy}, 4'd0);
`else
        check("jump_before_wrap", duty_out, 4'd5);
        wrap_pulse();
        check("jump_duty9", duty_out, 4'd9);
        check("jump_idle",  {3'b0, busy}, 4'd0);
        pulse_dec();
        pulse_dec();
        pulse_dec();
        check("jump_target6", target_out, 4'd6);
        check("jump_busy",    {3'b0, busy}, 4'd1);
        wrap_pulse();
        check("jump_duty6", duty_out, 4'd6);
`endif
        $display("retarget: duty=%0d target=%0d busy=%0d", duty_out, target_out, busy);

        // Reset during a ramp with period_wrap held high (one pulse per cycle).
        do_reset();
        host_set(4'd8);
        period_wrap = 1'b1;
        for (int n = 0; n < 6; n++) tick();
        check("hold_wrap_duty", duty_out, RAMP_EN ? 4'd6 : 4'd8);
        rst = 1'b1;
        tick();
        check("rst_mid_duty",   duty_out,   4'd5);
        check("rst_mid_target", target_out, 4'd5);
        check("rst_mid_busy",   {3'b0, busy}, 4'd0);
        tick();
        check("rst_mid_nostep", duty_out, 4'd5);
        period_wrap = 1'b0;
        rst = 1'b0;
        tick();
        check("rst_mid_ready", {3'b0, host_if.host_ready}, 4'd1);
        $display("reset mid-ramp: duty=%0d target=%0d", duty_out, target_out);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
